// File: rtl/im_loader_if.sv
// Byte-stream and instruction-SRAM write-port bundle for im_loader.
interface im_loader_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic [3:0]        im_w_en;
  logic [ADDR_W-1:0] im_address;
  logic [31:0]       im_write_data;

  modport master (
    input  s_valid, s_data,
    output s_ready, im_w_en, im_address, im_write_data
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, im_w_en, im_address, im_write_data
  );
endinterface

// File: rtl/im_loader.sv
// Boot-time instruction SRAM loader: packs a little-endian byte stream into words and holds the CPU until done.
// Optional trailing checksum word is enabled by defining IM_LOADER_CKSUM_EN.
module im_loader #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 16384
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [14:0]   len_words,
  im_loader_if.master   bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned LEN_W = 15;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RECV  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
`ifdef IM_LOADER_CKSUM_EN
  localparam logic [2:0] CHECK = 3'd4;
`endif

  logic [2:0]        state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0]  word_idx_q, word_idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [31:0]       acc_q, acc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              s_ready_q, s_ready_d;
  logic [3:0]        w_en_q, w_en_d;
  logic              busy_d, done_d, hold_d, err_d;
  logic              len_bad_c;
`ifdef IM_LOADER_CKSUM_EN
  logic [31:0]       sum_q, sum_d;
  logic              ck_q, ck_d;
`endif

  assign len_bad_c = (len_words == '0) || (32'(len_words) > MAX_WORDS);

  assign bus.s_ready       = s_ready_q;
  assign bus.im_w_en       = w_en_q;
  assign bus.im_address    = addr_q;
  assign bus.im_write_data = wdata_q;

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    len_d      = len_q;
    acc_d      = acc_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err;
`ifdef IM_LOADER_CKSUM_EN
    sum_d      = sum_q;
    ck_d       = ck_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          len_d      = len_words;
          byte_cnt_d = '0;
          word_idx_d = '0;
          acc_d      = '0;
          err_d      = len_bad_c;
          state_d    = len_bad_c ? DONE : RECV;
`ifdef IM_LOADER_CKSUM_EN
          sum_d      = '0;
          ck_d       = 1'b0;
`endif
        end
      end

      RECV: begin
        if (bus.s_valid && s_ready_q) begin
          acc_d[{byte_cnt_q, 3'b000} +: 8] = bus.s_data;
          byte_cnt_d = 2'(byte_cnt_q + 2'd1);
          if (byte_cnt_q == 2'd3) begin
`ifdef IM_LOADER_CKSUM_EN
            if (ck_q) state_d = CHECK;
            else
`endif
            begin
              state_d = WRITE;
              addr_d  = ADDR_W'(BASE_ADDR + (32'(word_idx_q) << 2));
              wdata_d = acc_d;
            end
          end
        end
      end

      WRITE: begin
        word_idx_d = LEN_W'(word_idx_q + 15'd1);
`ifdef IM_LOADER_CKSUM_EN
        sum_d = sum_q + wdata_q;
        // After the last data word one more word arrives: the checksum
        if (word_idx_d == len_q) ck_d = 1'b1;
        state_d = RECV;
`else
        state_d = (word_idx_d == len_q) ? DONE : RECV;
`endif
      end

`ifdef IM_LOADER_CKSUM_EN
      CHECK: begin
        state_d = DONE;
        err_d   = (acc_q != sum_q);
      end
`endif

      default: state_d = IDLE;
    endcase

    s_ready_d = (state_d == RECV);
    w_en_d    = (state_d == WRITE) ? 4'hF : 4'h0;
    busy_d    = (state_d != IDLE) && (state_d != DONE);
    done_d    = (state_d == DONE);
    hold_d    = (state_d != DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      len_q      <= '0;
      acc_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      s_ready_q  <= 1'b0;
      w_en_q     <= 4'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_hold   <= 1'b1;
`ifdef IM_LOADER_CKSUM_EN
      sum_q      <= '0;
      ck_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      s_ready_q  <= s_ready_d;
      w_en_q     <= w_en_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      cpu_hold   <= hold_d;
`ifdef IM_LOADER_CKSUM_EN
      sum_q      <= sum_d;
      ck_q       <= ck_d;
`endif
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: two instances (base 0x0000 and 0xFFFC) share one stimulus stream.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start;
  logic [14:0] len;
  logic        sv;
  logic [7:0]  sd;
  logic        hold1, busy1, done1, err1;
  logic        hold2, busy2, done2, err2;
  int          cyc = 0;
  int          t0;
  int          passed = 0;
  int          total  = 0;

  typedef struct {
    logic [3:0]  w;
    logic [15:0] a;
    logic [31:0] d;
    int          c;
  } wr_t;
  wr_t q1[$];
  wr_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  im_loader_if #(.ADDR_W(16)) bus1 ();
  im_loader_if #(.ADDR_W(16)) bus2 ();

  assign bus1.s_valid = sv;
  assign bus1.s_data  = sd;
  assign bus2.s_valid = sv;
  assign bus2.s_data  = sd;

  im_loader #(.ADDR_W(16), .BASE_ADDR(0), .MAX_WORDS(16384)) dut1 (
    .clk(clk), .rst(rst), .start(start), .len_words(len), .bus(bus1),
    .cpu_hold(hold1), .busy(busy1), .done(done1), .err(err1)
  );

  im_loader #(.ADDR_W(16), .BASE_ADDR(32'hFFFC), .MAX_WORDS(16384)) dut2 (
    .clk(clk), .rst(rst), .start(start), .len_words(len), .bus(bus2),
    .cpu_hold(hold2), .busy(busy2), .done(done2), .err(err2)
  );

  // Log every SRAM write cycle seen on either port
  always @(negedge clk) begin
    if (bus1.im_w_en != 4'h0) q1.push_back('{bus1.im_w_en, bus1.im_address, bus1.im_write_data, cyc});
    if (bus2.im_w_en != 4'h0) q2.push_back('{bus2.im_w_en, bus2.im_address, bus2.im_write_data, cyc});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [14:0] l);
    start = 1'b1;
    len   = l;
    t0    = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    sv = 1'b1;
    sd = b;
    @(negedge clk);
    while (!bus1.s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("s_ready_timeout", 32'(bus1.s_ready), 32'd1);
    @(posedge clk);
    #1;
    sv = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(done1 && done2) && n < 200) begin
      tick();
      n++;
    end
    chk("done_timeout", 32'(done1 && done2), 32'd1);
  endtask

  task automatic chk_writes2(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                             input int off0, input int off1);
    chk({tag, "_count1"}, 32'(q1.size()), 32'd2);
    chk({tag, "_count2"}, 32'(q2.size()), 32'd2);
    if (q1.size() == 2 && q2.size() == 2) begin
      chk({tag, "_wen"},   32'(q1[0].w), 32'hF);
      chk({tag, "_addr0"}, 32'(q1[0].a), 32'h0000);
      chk({tag, "_data0"}, q1[0].d, d0);
      chk({tag, "_t0"},    32'(q1[0].c - t0), 32'(off0));
      chk({tag, "_addr1"}, 32'(q1[1].a), 32'h0004);
      chk({tag, "_data1"}, q1[1].d, d1);
      chk({tag, "_t1"},    32'(q1[1].c - t0), 32'(off1));
      chk({tag, "_b_addr0"}, 32'(q2[0].a), 32'hFFFC);
      chk({tag, "_b_addr1"}, 32'(q2[1].a), 32'h0000);
      chk({tag, "_b_data1"}, q2[1].d, d1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    start = 1'b0;
    len   = '0;
    sv    = 1'b0;
    sd    = '0;
    #2 rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    // Idle after reset with no start
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_hold",  32'(hold1), 32'd1);
      chk("idle_ready", 32'(bus1.s_ready), 32'd0);
      chk("idle_wen",   32'(bus1.im_w_en), 32'd0);
      chk("idle_done",  32'(done1), 32'd0);
    end
    chk("idle_busy", 32'(busy1), 32'd0);
    chk("idle_err",  32'(err1), 32'd0);

    // Two-word load back-to-back; start pulsed in WRITE and RECV must be ignored
    q1.delete(); q2.delete();
    pulse_start(15'd2);
    chk("load_busy", 32'(busy1), 32'd1);
    chk("load_hold", 32'(hold1), 32'd1);
    send_word(32'h0000_0013);
    start = 1'b1;
    len   = 15'd0;
    send_byte(8'h93);
    start = 1'b0;
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h00);
`ifdef IM_LOADER_CKSUM_EN
    send_word(32'h0010_00A6);
`endif
    wait_done();
    chk_writes2("b2b", 32'h0000_0013, 32'h0010_0093, 5, 10);
    chk("b2b_err",  32'(err1), 32'd0);
    chk("b2b_hold", 32'(hold1), 32'd0);
    chk("b2b_busy", 32'(busy1), 32'd0);
    chk("b2b_err2", 32'(err2), 32'd0);

    // Same load with a 3-cycle gap between bytes 1 and 2
    q1.delete(); q2.delete();
    pulse_start(15'd2);
    send_byte(8'h13);
    send_byte(8'h00);
    repeat (3) tick();
    send_byte(8'h00);
    send_byte(8'h00);
    send_word(32'h0010_0093);
`ifdef IM_LOADER_CKSUM_EN
    send_word(32'h0010_00A6);
`endif
    wait_done();
    chk_writes2("stall", 32'h0000_0013, 32'h0010_0093, 8, 13);
    chk("stall_err", 32'(err1), 32'd0);

    // Illegal lengths: error on the next cycle, never a write
    q1.delete(); q2.delete();
    pulse_start(15'd0);
    chk("len0_done",  32'(done1), 32'd1);
    chk("len0_err",   32'(err1), 32'd1);
    chk("len0_busy",  32'(busy1), 32'd0);
    chk("len0_hold",  32'(hold1), 32'd0);
    repeat (5) tick();
    chk("len0_ready", 32'(bus1.s_ready), 32'd0);
    pulse_start(15'd16385);
    chk("lenmax_done", 32'(done1), 32'd1);
    chk("lenmax_err",  32'(err1), 32'd1);
    repeat (5) tick();
    chk("badlen_nowrite", 32'(q1.size() + q2.size()), 32'd0);

    // Reset after two bytes, then a fresh one-word load
    q1.delete(); q2.delete();
    pulse_start(15'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b0;
    #1;
    chk("rst_hold",  32'(hold1), 32'd1);
    chk("rst_ready", 32'(bus1.s_ready), 32'd0);
    chk("rst_busy",  32'(busy1), 32'd0);
    chk("rst_done",  32'(done1), 32'd0);
    chk("rst_addr",  32'(bus1.im_address), 32'd0);
    chk("rst_data",  bus1.im_write_data, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    pulse_start(15'd1);
    send_word(32'hDDCC_BBAA);
`ifdef IM_LOADER_CKSUM_EN
    send_word(32'hDDCC_BBAA);
`endif
    wait_done();
    chk("re_count", 32'(q1.size()), 32'd1);
    if (q1.size() == 1) begin
      chk("re_addr", 32'(q1[0].a), 32'h0000);
      chk("re_data", q1[0].d, 32'hDDCC_BBAA);
    end
    if (q2.size() == 1) chk("re_b_addr", 32'(q2[0].a), 32'hFFFC);
    chk("re_err",  32'(err1), 32'd0);
    chk("re_hold", 32'(hold1), 32'd0);

`ifdef IM_LOADER_CKSUM_EN
    // Corrupted checksum flags an error but still releases the CPU
    pulse_start(15'd1);
    send_word(32'h0000_0001);
    send_word(32'h0000_0002);
    wait_done();
    chk("ck_err",  32'(err1), 32'd1);
    chk("ck_hold", 32'(hold1), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
